// File: rtl/i2s_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// i2s_frame_sequencer_if
// Groups the control, timing and buffer-scheduling signals of the I2S frame
// sequencer.
//   master : the sequencer. It drives ws, the capture window, the buffer
//            write strobe, the read acknowledge and the occupancy flags.
//   slave  : the surrounding logic. It drives enable, clear_overrun and
//            rd_req, and observes everything else.
// Widths follow NUMBER_OF_BITS (bit_index) and BUFFER_DEPTH (addresses, count).
// ---------------------------------------------------------------------------
interface i2s_frame_sequencer_if #(
  parameter int NUMBER_OF_BITS = 8,
  parameter int BUFFER_DEPTH   = 10
);
  localparam int BW = $clog2(NUMBER_OF_BITS);
  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int CW = $clog2(BUFFER_DEPTH + 1);

  logic          enable;
  logic          clear_overrun;
  logic          rd_req;
  logic          ws;
  logic          capture_en;
  logic [BW-1:0] bit_index;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          wr_channel;
  logic          rd_ack;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overrun;

  modport master (
    input  enable, clear_overrun, rd_req,
    output ws, capture_en, bit_index, wr_en, wr_addr, wr_channel,
    output rd_ack, rd_addr, count, full, empty, overrun
  );

  modport slave (
    output enable, clear_overrun, rd_req,
    input  ws, capture_en, bit_index, wr_en, wr_addr, wr_channel,
    input  rd_ack, rd_addr, count, full, empty, overrun
  );
endinterface

// File: rtl/i2s_frame_sequencer.sv
// ---------------------------------------------------------------------------
// i2s_frame_sequencer
// Timing master and write/read scheduler for the I2S capture path.
//   - Divides clk into ws half-periods of HALF_FRAME_CYCLES cycles.
//   - After each ws edge it waits one bit (I2S delay), then opens a
//     NUMBER_OF_BITS-cycle capture window (MSB first). On the cycle after
//     that it commits the word into a circular buffer of BUFFER_DEPTH
//     entries.
//   - Serves one consumer through rd_req/rd_ack. It tracks occupancy,
//     full/empty and a sticky overrun flag.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : i2s_frame_sequencer_if.master
//           inputs  : enable, clear_overrun, rd_req
//           outputs : ws, capture_en, bit_index, wr_en, wr_addr, wr_channel,
//                     rd_ack, rd_addr, count, full, empty, overrun
// ---------------------------------------------------------------------------
module i2s_frame_sequencer #(
  parameter int NUMBER_OF_BITS    = 8,
  parameter int HALF_FRAME_CYCLES = 32,
  parameter int BUFFER_DEPTH      = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  i2s_frame_sequencer_if.master        bus
);
  localparam int BW = $clog2(NUMBER_OF_BITS);
  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int CW = $clog2(BUFFER_DEPTH + 1);
  localparam int TW = $clog2(HALF_FRAME_CYCLES);

  localparam logic [TW-1:0] CNT_LAST   = TW'(HALF_FRAME_CYCLES - 1);
  localparam logic [BW-1:0] BIT_MSB    = BW'(NUMBER_OF_BITS - 1);
  localparam logic [AW-1:0] ADDR_LAST  = AW'(BUFFER_DEPTH - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(BUFFER_DEPTH);

  typedef enum logic [2:0] {IDLE, WAIT_EDGE, DELAY, CAPTURE, COMMIT} state_t;

  state_t        r_state;
  logic [TW-1:0] r_cnt;
  logic          r_ws;
  logic          r_capture_en;
  logic [BW-1:0] r_bit_index;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic          r_wr_channel;
  logic [AW-1:0] r_wr_ptr;
  logic          r_rd_ack;
  logic [AW-1:0] r_rd_addr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overrun;

  logic w_ws_edge;
  logic w_full;
  logic w_empty;
  logic w_commit;
  logic w_write;
  logic w_drop;
  logic w_pop;

  // Circular pointer advance; the depth need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == ADDR_LAST) ? '0 : p + 1'b1;
  endfunction

  // ws toggles at the end of this cycle.
  assign w_ws_edge = bus.enable && (r_cnt == CNT_LAST);
  assign w_full    = (r_count == COUNT_FULL);
  assign w_empty   = (r_count == '0);

  // The last capture bit is being sampled, so the COMMIT cycle follows.
  // The write/drop decision is taken here, on the same edge as any pop
  // decision. Full is therefore judged on the pre-pop occupancy.
  assign w_commit = bus.enable && (r_state == CAPTURE) && (r_bit_index == '0);
  assign w_write  = w_commit && !w_full;
  assign w_drop   = w_commit && w_full;
  assign w_pop    = bus.rd_req && !w_empty;

  // ws half-period timer. It freezes while disabled, so re-enabling
  // resumes the frame where it stopped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_ws  <= 1'b0;
    end else if (bus.enable) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        r_ws  <= ~r_ws;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Capture/commit scheduler. Losing enable abandons any partial word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_capture_en <= 1'b0;
      r_bit_index  <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_channel <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (!bus.enable) begin
        r_state      <= IDLE;
        r_capture_en <= 1'b0;
      end else begin
        case (r_state)
          IDLE:      r_state <= WAIT_EDGE;
          WAIT_EDGE: if (w_ws_edge) r_state <= DELAY;
          DELAY: begin
            r_state      <= CAPTURE;
            r_capture_en <= 1'b1;
            r_bit_index  <= BIT_MSB;
          end
          CAPTURE: begin
            if (r_bit_index == '0) begin
              r_state      <= COMMIT;
              r_capture_en <= 1'b0;
              r_wr_en      <= w_write;
              r_wr_addr    <= r_wr_ptr;
              r_wr_channel <= r_ws;
            end else begin
              r_bit_index <= r_bit_index - 1'b1;
            end
          end
          // With the shortest legal half-period the next ws edge can
          // coincide with COMMIT; catching it here keeps that frame.
          COMMIT:    r_state <= w_ws_edge ? DELAY : WAIT_EDGE;
          default:   r_state <= IDLE;
        endcase
      end
    end
  end

  // Buffer bookkeeping: pointers, occupancy, read port and overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rd_ack  <= 1'b0;
      r_rd_addr <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_rd_ack <= w_pop;
      if (w_pop) begin
        r_rd_addr <= r_rd_ptr;
        r_rd_ptr  <= ptr_inc(r_rd_ptr);
      end
      if (w_write) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A new drop outranks a simultaneous clear.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (bus.clear_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.ws         = r_ws;
  assign bus.capture_en = r_capture_en;
  assign bus.bit_index  = r_bit_index;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_channel = r_wr_channel;
  assign bus.rd_ack     = r_rd_ack;
  assign bus.rd_addr    = r_rd_addr;
  assign bus.count      = r_count;
  assign bus.full       = w_full;
  assign bus.empty      = w_empty;
  assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2s_frame_sequencer
// Self-checking bench for i2s_frame_sequencer (N=8, HALF=32, DEPTH=10).
// The reference model works from the frame rules:
//   - ws is derived from the number of enabled cycles.
//   - A capture window opens k cycles after a ws edge only if enable has
//     been held long enough.
//   - The buffer is modelled as a queue of written addresses.
// The bench first applies a vector table covering the first frame, then
// hand-written sequences for fill/overrun, drain-with-wrap, commit+pop
// and enable loss. It ends with randomized traffic and a reset taken
// with a read pending.
// ---------------------------------------------------------------------------
module tb_i2s_frame_sequencer;
  localparam int N    = 8;
  localparam int HALF = 32;
  localparam int D    = 10;

  logic clk;
  logic reset;

  i2s_frame_sequencer_if #(.NUMBER_OF_BITS(N), .BUFFER_DEPTH(D)) bus ();

  i2s_frame_sequencer #(
    .NUMBER_OF_BITS(N),
    .HALF_FRAME_CYCLES(HALF),
    .BUFFER_DEPTH(D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  // Reference model state.
  int m_cyc;        // cycle index since enable was first applied
  int m_en_cycles;  // enabled cycles seen so far (drives ws)
  int m_streak;     // consecutive enabled cycles ending at the last edge
  int m_edge_t;     // cycle at which the most recent ws edge became visible
  int m_writes;     // accepted writes (write pointer = m_writes % D)
  bit m_ovr;
  int q[$];         // addresses currently held in the buffer

  // Expected outputs for the current cycle.
  bit e_ws, e_cap, e_wr_en, e_wr_ch, e_ack;
  int e_bit, e_wr_addr, e_rd_addr;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, m_cyc);
  endtask

  task automatic model_reset();
    m_cyc = 0; m_en_cycles = 0; m_streak = 0; m_edge_t = -1000;
    m_writes = 0; m_ovr = 1'b0; q.delete();
    e_ws = 0; e_cap = 0; e_wr_en = 0; e_wr_ch = 0; e_ack = 0;
    e_bit = 0; e_wr_addr = 0; e_rd_addr = 0;
  endtask

  task automatic compare_all();
    check("ws", bus.ws, e_ws);
    check("capture_en", bus.capture_en, e_cap);
    if (e_cap) check("bit_index", bus.bit_index, e_bit);
    check("wr_en", bus.wr_en, e_wr_en);
    if (e_wr_en) begin
      check("wr_addr", bus.wr_addr, e_wr_addr);
      check("wr_channel", bus.wr_channel, e_wr_ch);
    end
    check("rd_ack", bus.rd_ack, e_ack);
    if (e_ack) check("rd_addr", bus.rd_addr, e_rd_addr);
    check("count", bus.count, q.size());
    check("full", bus.full, q.size() == D);
    check("empty", bus.empty, q.size() == 0);
    check("overrun", bus.overrun, m_ovr);
  endtask

  // One clock: sample inputs, clock the DUT, advance the model, then
  // compare on the falling edge.
  task automatic step();
    bit en, rq, clr, commit, was_full, pop;
    int k;
    en  = bus.enable;
    rq  = bus.rd_req;
    clr = bus.clear_overrun;
    @(posedge clk);
    m_cyc++;
    if (en) m_en_cycles++;
    m_streak = en ? m_streak + 1 : 0;
    if (en && (m_en_cycles % HALF == 0)) m_edge_t = m_cyc;
    e_ws = ((m_en_cycles / HALF) % 2) != 0;
    k = m_cyc - m_edge_t;
    // Capture k cycles after the edge needs enable from edge-2 onwards.
    e_cap = (k >= 1) && (k <= N) && (m_streak >= k + 2);
    if (e_cap) e_bit = N - k;
    commit   = (k == N + 1) && (m_streak >= N + 3);
    was_full = (q.size() == D);
    pop      = rq && (q.size() != 0);
    e_ack    = pop;
    e_wr_en  = commit && !was_full;
    if (pop) e_rd_addr = q.pop_front();
    if (e_wr_en) begin
      e_wr_addr = m_writes % D;
      e_wr_ch   = e_ws;
      q.push_back(e_wr_addr);
      m_writes++;
    end
    if (commit && was_full) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    @(negedge clk);
    compare_all();
    if (bus.wr_en) $display("cycle %0d: write addr=%0d ch=%0d count=%0d", m_cyc, bus.wr_addr, bus.wr_channel, bus.count);
    if (bus.rd_ack) $display("cycle %0d: read  addr=%0d count=%0d", m_cyc, bus.rd_addr, bus.count);
  endtask

  task automatic run_to(input int c);
    while (m_cyc < c) step();
  endtask

  typedef struct {
    int cyc;  bit rq;
    bit ws;   bit cap; int bidx;
    bit wr;   int waddr; bit wch;
    bit ack;  int raddr; int cnt;
  } vec_t;

  vec_t vecs[10];
  int   rd_pct[6];

  initial begin
    n_pass = 0;
    n_total = 0;
    // cyc rq  ws cap bidx wr waddr wch ack raddr cnt
    vecs[0] = '{0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2] = '{32, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[3] = '{33, 0, 1, 1, 7, 0, 0, 0, 0, 0, 0};
    vecs[4] = '{36, 0, 1, 1, 4, 0, 0, 0, 0, 0, 0};
    vecs[5] = '{40, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[6] = '{41, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1};
    vecs[7] = '{42, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[8] = '{43, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[9] = '{45, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    rd_pct = '{0, 50, 1, 90, 30, 0};

    reset = 1'b1;
    bus.enable = 1'b0;
    bus.rd_req = 1'b0;
    bus.clear_overrun = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("reset_empty", bus.empty, 1);
    check("reset_full", bus.full, 0);
    check("reset_overrun", bus.overrun, 0);
    bus.enable = 1'b1;

    // First frame and a single read, from the vector table.
    for (int i = 0; i < 10; i++) begin
      run_to(vecs[i].cyc);
      check("tbl_ws", bus.ws, vecs[i].ws);
      check("tbl_capture_en", bus.capture_en, vecs[i].cap);
      if (vecs[i].cap) check("tbl_bit_index", bus.bit_index, vecs[i].bidx);
      check("tbl_wr_en", bus.wr_en, vecs[i].wr);
      if (vecs[i].wr) begin
        check("tbl_wr_addr", bus.wr_addr, vecs[i].waddr);
        check("tbl_wr_channel", bus.wr_channel, vecs[i].wch);
      end
      check("tbl_rd_ack", bus.rd_ack, vecs[i].ack);
      if (vecs[i].ack) check("tbl_rd_addr", bus.rd_addr, vecs[i].raddr);
      check("tbl_count", bus.count, vecs[i].cnt);
      check("tbl_empty", bus.empty, vecs[i].cnt == 0);
      bus.rd_req = vecs[i].rq;
    end

    // Fill to full with wrap, then the overrun on the following commit.
    run_to(361);
    check("fill_count", bus.count, 10);
    check("fill_full", bus.full, 1);
    check("fill_wrap_addr", bus.wr_addr, 0);
    run_to(393);
    check("ovr_wr_en", bus.wr_en, 0);
    check("ovr_flag", bus.overrun, 1);
    check("ovr_count", bus.count, 10);
    run_to(394);
    bus.clear_overrun = 1'b1;
    step();
    bus.clear_overrun = 1'b0;
    check("ovr_cleared", bus.overrun, 0);

    // Held rd_req drains all ten entries, wrapping rd_addr 8,9,0.
    bus.rd_req = 1'b1;
    run_to(403);
    check("drain_addr8", bus.rd_addr, 8);
    step();
    check("drain_addr9", bus.rd_addr, 9);
    step();
    check("drain_addr0", bus.rd_addr, 0);
    check("drain_ack", bus.rd_ack, 1);
    check("drain_empty", bus.empty, 1);
    step();
    check("drain_no_ack", bus.rd_ack, 0);
    bus.rd_req = 1'b0;

    // Pop landing on a commit cycle with count 4.
    run_to(552);
    check("pre_commit_count", bus.count, 4);
    bus.rd_req = 1'b1;
    step();
    bus.rd_req = 1'b0;
    check("both_wr_en", bus.wr_en, 1);
    check("both_rd_ack", bus.rd_ack, 1);
    check("both_count", bus.count, 4);
    check("both_wr_addr", bus.wr_addr, 5);
    check("both_rd_addr", bus.rd_addr, 1);

    // Enable lost on the third capture cycle, restored later.
    run_to(579);
    check("drop_bit_index", bus.bit_index, 5);
    bus.enable = 1'b0;
    step();
    check("drop_capture_off", bus.capture_en, 0);
    run_to(590);
    check("drop_ws_frozen", bus.ws, 0);
    check("drop_count", bus.count, 4);
    bus.enable = 1'b1;
    run_to(618);
    check("resume_wait", bus.capture_en, 0);
    step();
    check("resume_ws_edge", bus.ws, 1);
    step();
    check("resume_capture", bus.capture_en, 1);
    run_to(628);
    check("resume_commit", bus.wr_en, 1);
    check("resume_wr_addr", bus.wr_addr, 6);
    check("resume_count", bus.count, 5);

    // Randomized traffic, six phases with different read pressure.
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 500; i++) begin
        bus.enable        = ($urandom_range(0, 99) != 0);
        bus.rd_req        = ($urandom_range(0, 99) < rd_pct[ph]);
        bus.clear_overrun = ($urandom_range(0, 49) == 0);
        step();
      end
    end

    // Reset with a read pending overrides everything.
    bus.rd_req = 1'b1;
    bus.clear_overrun = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.rd_req = 1'b0;
    check("rst_rd_ack", bus.rd_ack, 0);
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_overrun", bus.overrun, 0);
    check("rst_ws", bus.ws, 0);
    check("rst_capture_en", bus.capture_en, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/i2s_frame_sequencer.md
Name: i2s_frame_sequencer

Overview:
- Timing master and write/read scheduler for the I2S capture path.
- Generates the word-select (ws) line and the per-bit capture window for the serial-to-parallel shifter.
- Commits each finished channel word into a circular sample buffer.
- Serves a single consumer through a req/ack read port, with occupancy, full/empty and overrun tracking.

Parameters:
- NUMBER_OF_BITS, 8: bits per channel word (capture window length).
- HALF_FRAME_CYCLES, 32: clk cycles per ws half-period. Must be >= NUMBER_OF_BITS+2.
- BUFFER_DEPTH, 10: sample-buffer entries. Need not be a power of 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run control.
- clear_overrun  in  1  single-cycle clear of the sticky overrun flag.
- rd_req  in  1  consumer requests one buffered word.
- ws  out  1  word select: 0 = left, 1 = right.
- capture_en  out  1  shifter samples data_in on this cycle.
- bit_index  out  $clog2(NUMBER_OF_BITS)  current bit, MSB first.
- wr_en  out  1  one-cycle buffer write strobe.
- wr_addr  out  $clog2(BUFFER_DEPTH)  buffer write address.
- wr_channel  out  1  channel of the committed word.
- rd_ack  out  1  one-cycle pop acknowledge.
- rd_addr  out  $clog2(BUFFER_DEPTH)  address being popped, valid with rd_ack.
- count  out  $clog2(BUFFER_DEPTH+1)  buffer occupancy.
- full  out  1  count == BUFFER_DEPTH.
- empty  out  1  count == 0.
- overrun  out  1  sticky: a word was dropped because the buffer was full.

Behaviour:
- Reset: all of the following are 0 and the FSM is IDLE: ws, cycle counter, capture_en, bit_index, wr_en, wr_addr, wr_channel, rd_ack, rd_addr, count, write/read pointers, overrun. empty=1, full=0.
- Cycle counter cnt runs only while enable=1.
  - When cnt == HALF_FRAME_CYCLES-1: cnt <= 0 and ws <= ~ws (the "ws edge").
  - Otherwise cnt increments.
  - First edge comes HALF_FRAME_CYCLES cycles after enable rises from reset.
- FSM states: IDLE, WAIT_EDGE, DELAY, CAPTURE, COMMIT.
  - IDLE -> WAIT_EDGE when enable=1.
  - WAIT_EDGE -> DELAY on the cycle ws toggles. DELAY is the I2S one-bit delay; capture_en=0.
  - DELAY -> CAPTURE.
  - CAPTURE lasts exactly NUMBER_OF_BITS cycles with capture_en=1. bit_index counts NUMBER_OF_BITS-1 down to 0, and ws is stable throughout.
  - CAPTURE -> COMMIT after bit_index 0.
  - COMMIT lasts 1 cycle: wr_en=1 (unless full), wr_addr=wr_ptr, wr_channel=ws. Then -> WAIT_EDGE.
- Latency: with the ws edge visible at cycle T, capture_en is high T+1..T+NUMBER_OF_BITS, and wr_en fires at T+NUMBER_OF_BITS+1.
- Full at commit: wr_en stays 0, the word is dropped, and overrun <= 1. wr_ptr and count are unchanged.
- overrun clears only on reset or clear_overrun. If a new overrun and clear_overrun occur in the same cycle, set wins.
- Read port:
  - If rd_req=1 and count != 0 in cycle t, then rd_ack=1 in cycle t+1 with rd_addr = rd_ptr, and rd_ptr/count update in that same cycle.
  - A held rd_req gives back-to-back acks until empty.
  - rd_req while empty is ignored; no error flag.
- Pointers wrap from BUFFER_DEPTH-1 to 0.
- Simultaneous write and pop in the same cycle: count unchanged, both pointers advance.
- A write into a full buffer is dropped even if a pop occurs in the same cycle (full is evaluated before the pop).
- enable deasserted mid-operation:
  - The next cycle goes to IDLE: capture_en=0, no COMMIT, partial word abandoned.
  - cnt holds and ws holds. Buffer contents, count and the read port continue operating.
- Re-enable resumes cnt from its held value.
- Reset mid-operation overrides everything, including a pending rd_ack.

Test Plan (defaults N=8, HALF=32, DEPTH=10):
1. Reset, then enable at cycle 0 -> ws rises at cycle 32; capture_en high cycles 33–40 with bit_index 7..0; wr_en at cycle 41 with wr_addr=0, wr_channel=1; count=1.
2. Run 11 half-frames with no reads -> count=10 and full=1 after the 10th commit; 11th commit has wr_en=0 and overrun=1. clear_overrun pulse -> overrun=0.
3. count=3, rd_req held high -> three rd_ack pulses on consecutive cycles with rd_addr 0,1,2; then empty=1 and no further acks.
4. rd_req timed so the pop lands on a COMMIT cycle with count=4 -> count stays 4; wr_ptr and rd_ptr both advance by 1.
5. enable dropped on the 3rd capture cycle -> capture_en=0 next cycle, no wr_en, count unchanged, ws frozen. Re-enable -> next capture starts only after a fresh ws edge.
6. 12 writes interleaved with 12 reads -> wr_addr and rd_addr sequences each run …8,9,0,1; count never exceeds 1; overrun=0.
